// File: rtl/rf_pkg.sv
// Shared defaults and types for the register-file read server.
package rf_pkg;

    localparam int RF_NUM_REG     = 8;
    localparam int RF_REG_BIT     = 16;
    localparam int RF_INST_ID_BIT = 8;
    localparam int RF_REG_ID_BIT  = $clog2(RF_NUM_REG);
    localparam int RF_FBK_DEPTH   = 2;

    // One buffered operand pair, as returned to the functional unit.
    typedef struct packed {
        logic [RF_REG_BIT-1:0] reg0_val;
        logic [RF_REG_BIT-1:0] reg1_val;
    } rf_fbk_entry_t;

endpackage

// File: rtl/rf_fbk_fifo.sv
// Synchronous in-order FIFO with count-based full, used as the operand
// feedback buffer. push_rdy depends only on the registered count.
module rf_fbk_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_data
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Full is judged on the count at the start of the cycle, so a full
    // buffer refuses a push even when it pops in the same cycle.
    assign push_rdy = (count != FULL_CNT);
    assign pop_vld  = (count != '0);
    assign push     = push_vld && push_rdy;
    assign pop      = pop_vld && pop_rdy;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy control; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are meaningless while the slot is not counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rf_read_server.sv
// Register-file read server: holds the architectural registers, answers
// two-operand read requests through a flow-controlled feedback buffer and
// sinks write-backs. Optional macro RF_WRITE_BYPASS_EN makes a same-cycle
// write visible to the read sample (write-first); otherwise read-first.
module rf_read_server
    import rf_pkg::*;
#(
    parameter int NUM_REG     = RF_NUM_REG,
    parameter int REG_BIT     = RF_REG_BIT,
    parameter int INST_ID_BIT = RF_INST_ID_BIT,
    parameter int FBK_DEPTH   = RF_FBK_DEPTH,
    parameter int REG_ID_BIT  = $clog2(NUM_REG)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   read_req_vld,
    output logic                   read_req_rdy,
    input  logic [REG_ID_BIT-1:0]  read_reg0_id,
    input  logic [REG_ID_BIT-1:0]  read_reg1_id,
    output logic                   read_fbk_vld,
    input  logic                   read_fbk_rdy,
    output logic [REG_BIT-1:0]     read_reg0_val,
    output logic [REG_BIT-1:0]     read_reg1_val,
    input  logic                   write_back_vld,
    output logic                   write_back_rdy,
    input  logic [INST_ID_BIT-1:0] write_back_id,
    input  logic [REG_ID_BIT-1:0]  write_back_reg_id,
    input  logic [REG_BIT-1:0]     write_back_val,
    input  logic [REG_ID_BIT-1:0]  dbg_reg_id,
    output logic [REG_BIT-1:0]     dbg_reg_val,
    output logic                   idle
);

    localparam int ENTRY_W = 2 * REG_BIT;

    logic [REG_BIT-1:0] regs [NUM_REG];
    logic [REG_BIT-1:0] src0_val_p0;
    logic [REG_BIT-1:0] src1_val_p0;
    logic [ENTRY_W-1:0] fbk_data_p1;
    logic               vld_p1;
    logic               unused_wb_id;

    // The instruction id only tags the write-back; storage does not need it.
    assign unused_wb_id   = ^write_back_id;
    assign write_back_rdy = 1'b1;
    assign dbg_reg_val    = regs[dbg_reg_id];

    // Architectural register array; every valid write-back commits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs[i] <= '0;
            end
        end else if (write_back_vld) begin
            regs[write_back_reg_id] <= write_back_val;
        end
    end

    // Stage p0: sample both sources in the accept cycle.
    always_comb begin
        src0_val_p0 = regs[read_reg0_id];
        src1_val_p0 = regs[read_reg1_id];
`ifdef RF_WRITE_BYPASS_EN
        if (write_back_vld && (write_back_reg_id == read_reg0_id)) begin
            src0_val_p0 = write_back_val;
        end
        if (write_back_vld && (write_back_reg_id == read_reg1_id)) begin
            src1_val_p0 = write_back_val;
        end
`endif
    end

    // Stage p1: buffered operand pairs, head presented to the unit.
    rf_fbk_fifo #(
        .DEPTH (FBK_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fbk_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_vld  (read_req_vld),
        .push_rdy  (read_req_rdy),
        .push_data ({src0_val_p0, src1_val_p0}),
        .pop_vld   (vld_p1),
        .pop_rdy   (read_fbk_rdy),
        .pop_data  (fbk_data_p1)
    );

    assign read_fbk_vld  = vld_p1;
    assign read_reg0_val = fbk_data_p1[ENTRY_W-1:REG_BIT];
    assign read_reg1_val = fbk_data_p1[REG_BIT-1:0];
    assign idle          = !vld_p1;

endmodule

// File: tb/tb_rf_read_server.sv
// Bench for rf_read_server: directed table of cycles with hand-computed
// expectations, followed by random traffic checked against a queue-based
// model of the register file and feedback buffer.
module tb_rf_read_server;
    import rf_pkg::*;

    localparam int DEPTH = 2;
`ifdef RF_WRITE_BYPASS_EN
    localparam logic [15:0] BYP = 16'hBEEF;
    localparam bit BYPASS = 1'b1;
`else
    localparam logic [15:0] BYP = 16'h0000;
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_req_vld;
    logic        read_req_rdy;
    logic [2:0]  read_reg0_id;
    logic [2:0]  read_reg1_id;
    logic        read_fbk_vld;
    logic        read_fbk_rdy;
    logic [15:0] read_reg0_val;
    logic [15:0] read_reg1_val;
    logic        write_back_vld;
    logic        write_back_rdy;
    logic [7:0]  write_back_id;
    logic [2:0]  write_back_reg_id;
    logic [15:0] write_back_val;
    logic [2:0]  dbg_reg_id;
    logic [15:0] dbg_reg_val;
    logic        idle;

    always #5 clk = ~clk;

    rf_read_server dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .read_req_vld      (read_req_vld),
        .read_req_rdy      (read_req_rdy),
        .read_reg0_id      (read_reg0_id),
        .read_reg1_id      (read_reg1_id),
        .read_fbk_vld      (read_fbk_vld),
        .read_fbk_rdy      (read_fbk_rdy),
        .read_reg0_val     (read_reg0_val),
        .read_reg1_val     (read_reg1_val),
        .write_back_vld    (write_back_vld),
        .write_back_rdy    (write_back_rdy),
        .write_back_id     (write_back_id),
        .write_back_reg_id (write_back_reg_id),
        .write_back_val    (write_back_val),
        .dbg_reg_id        (dbg_reg_id),
        .dbg_reg_val       (dbg_reg_val),
        .idle              (idle)
    );

    typedef struct {
        logic        rstn;
        logic        rv;
        logic [2:0]  r0;
        logic [2:0]  r1;
        logic        fr;
        logic        wv;
        logic [2:0]  wr;
        logic [15:0] wval;
        logic [2:0]  dbg;
        logic        e_vld;
        logic        e_rdy;
        logic [15:0] e_v0;
        logic [15:0] e_v1;
        logic [15:0] e_dbg;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference state: register contents and the queue of pending pairs.
    logic [15:0]   mregs [8];
    rf_fbk_entry_t mq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rstn, input logic rv, input logic [2:0] r0,
                                input logic [2:0] r1, input logic fr, input logic wv,
                                input logic [2:0] wr, input logic [15:0] wval,
                                input logic [2:0] dbg, input logic e_vld, input logic e_rdy,
                                input logic [15:0] e_v0, input logic [15:0] e_v1,
                                input logic [15:0] e_dbg);
        vec_t v;
        v.rstn = rstn; v.rv = rv; v.r0 = r0; v.r1 = r1; v.fr = fr;
        v.wv = wv; v.wr = wr; v.wval = wval; v.dbg = dbg;
        v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_v0 = e_v0; v.e_v1 = e_v1; v.e_dbg = e_dbg;
        return v;
    endfunction

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic cycle(input vec_t v, input bit use_table);
        rf_fbk_entry_t e;
        bit acc;
        bit pop;
        rst_n             = v.rstn;
        read_req_vld      = v.rv;
        read_reg0_id      = v.r0;
        read_reg1_id      = v.r1;
        read_fbk_rdy      = v.fr;
        write_back_vld    = v.wv;
        write_back_reg_id = v.wr;
        write_back_val    = v.wval;
        write_back_id     = 8'($urandom);
        dbg_reg_id        = v.dbg;
        #1;
        if (use_table) begin
            chk("tbl_vld", 32'(read_fbk_vld), 32'(v.e_vld));
            chk("tbl_idle", 32'(idle), 32'(!v.e_vld));
            chk("tbl_rdy", 32'(read_req_rdy), 32'(v.e_rdy));
            chk("tbl_dbg", 32'(dbg_reg_val), 32'(v.e_dbg));
            if (v.e_vld) begin
                chk("tbl_val0", 32'(read_reg0_val), 32'(v.e_v0));
                chk("tbl_val1", 32'(read_reg1_val), 32'(v.e_v1));
            end
        end
        chk("mdl_vld", 32'(read_fbk_vld), 32'(mq.size() != 0));
        chk("mdl_idle", 32'(idle), 32'(mq.size() == 0));
        chk("mdl_rdy", 32'(read_req_rdy), 32'(mq.size() < DEPTH));
        chk("mdl_wb_rdy", 32'(write_back_rdy), 32'd1);
        chk("mdl_dbg", 32'(dbg_reg_val), 32'(mregs[v.dbg]));
        if (mq.size() != 0) begin
            chk("mdl_val0", 32'(read_reg0_val), 32'(mq[0].reg0_val));
            chk("mdl_val1", 32'(read_reg1_val), 32'(mq[0].reg1_val));
        end
        if (!v.rstn) begin
            for (int i = 0; i < 8; i++) mregs[i] = '0;
            mq.delete();
        end else begin
            acc = v.rv && (mq.size() < DEPTH);
            pop = (mq.size() != 0) && v.fr;
            e.reg0_val = (BYPASS && v.wv && v.wr == v.r0) ? v.wval : mregs[v.r0];
            e.reg1_val = (BYPASS && v.wv && v.wr == v.r1) ? v.wval : mregs[v.r1];
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(e);
            if (v.wv) mregs[v.wr] = v.wval;
        end
        @(negedge clk);
    endtask

    vec_t vt [$];
    vec_t rv;

    initial begin
        rst_n = 1'b0; read_req_vld = 1'b0; read_reg0_id = '0; read_reg1_id = '0;
        read_fbk_rdy = 1'b0; write_back_vld = 1'b0; write_back_reg_id = '0;
        write_back_val = '0; write_back_id = '0; dbg_reg_id = '0;
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // rstn rv r0 r1 fr wv wr wval dbg | vld rdy v0 v1 dbg
        vt.push_back(mk(1,0,0,0,1,1,3,16'h1234,3, 0,1,0,0,16'h0000));
        vt.push_back(mk(1,0,0,0,1,1,5,16'h00FF,3, 0,1,0,0,16'h1234));
        vt.push_back(mk(1,1,3,5,1,0,0,0,5,        0,1,0,0,16'h00FF));
        vt.push_back(mk(1,0,0,0,1,0,0,0,3,        1,1,16'h1234,16'h00FF,16'h1234));
        vt.push_back(mk(1,1,2,2,1,1,2,16'hBEEF,2, 0,1,0,0,16'h0000));
        vt.push_back(mk(1,0,0,0,0,0,0,0,2,        1,1,BYP,BYP,16'hBEEF));
        vt.push_back(mk(1,0,0,0,1,0,0,0,2,        1,1,BYP,BYP,16'hBEEF));
        vt.push_back(mk(1,0,0,0,1,0,0,0,2,        0,1,0,0,16'hBEEF));
        vt.push_back(mk(1,0,0,0,1,1,1,16'h0011,1, 0,1,0,0,16'h0000));
        vt.push_back(mk(1,1,1,3,0,0,0,0,1,        0,1,0,0,16'h0011));
        vt.push_back(mk(1,1,5,2,0,0,0,0,1,        1,1,16'h0011,16'h1234,16'h0011));
        vt.push_back(mk(1,1,3,3,0,0,0,0,1,        1,0,16'h0011,16'h1234,16'h0011));
        vt.push_back(mk(1,1,3,3,0,0,0,0,1,        1,0,16'h0011,16'h1234,16'h0011));
        vt.push_back(mk(1,1,3,3,1,0,0,0,1,        1,0,16'h0011,16'h1234,16'h0011));
        vt.push_back(mk(1,1,3,3,0,0,0,0,1,        1,1,16'h00FF,16'hBEEF,16'h0011));
        vt.push_back(mk(1,0,0,0,1,0,0,0,1,        1,0,16'h00FF,16'hBEEF,16'h0011));
        vt.push_back(mk(1,0,0,0,1,0,0,0,1,        1,1,16'h1234,16'h1234,16'h0011));
        vt.push_back(mk(1,0,0,0,1,0,0,0,4,        0,1,0,0,16'h0000));
        vt.push_back(mk(1,0,0,0,1,1,4,16'h0007,4, 0,1,0,0,16'h0000));
        vt.push_back(mk(1,1,4,4,0,0,0,0,4,        0,1,0,0,16'h0007));
        vt.push_back(mk(1,0,0,0,0,1,4,16'h0009,4, 1,1,16'h0007,16'h0007,16'h0007));
        vt.push_back(mk(1,0,0,0,1,0,0,0,4,        1,1,16'h0007,16'h0007,16'h0009));
        vt.push_back(mk(1,0,0,0,1,0,0,0,1,        0,1,0,0,16'h0011));
        vt.push_back(mk(1,0,0,0,1,1,1,16'h0055,1, 0,1,0,0,16'h0011));
        vt.push_back(mk(1,1,1,1,0,0,0,0,1,        0,1,0,0,16'h0055));
        vt.push_back(mk(1,1,1,3,0,0,0,0,1,        1,1,16'h0055,16'h0055,16'h0055));
        vt.push_back(mk(0,1,2,2,0,1,1,16'h0077,1, 1,0,16'h0055,16'h0055,16'h0055));
        vt.push_back(mk(1,0,0,0,1,0,0,0,1,        0,1,0,0,16'h0000));

        foreach (vt[i]) cycle(vt[i], 1'b1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            rv = mk(($urandom_range(0, 63) != 0), $urandom_range(0, 1) == 1,
                    3'($urandom), 3'($urandom), $urandom_range(0, 9) < 6,
                    $urandom_range(0, 1) == 1, 3'($urandom), 16'($urandom),
                    3'($urandom), 0, 0, 0, 0, 0);
            cycle(rv, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_read_server.md
Name: rf_read_server

Overview:
- Register-file side of the functional-unit operand/write-back protocol.
- Holds NUM_REG architectural registers.
- Answers a functional unit's read requests (two source registers per request) with a registered, flow-controlled feedback stream.
- Sinks the unit's write-back stream into the register array.
- Sits between the scoreboard-driven functional unit and the architectural state.

Parameters:
- NUM_REG, 8, number of architectural registers
- REG_BIT, 16, register data width
- INST_ID_BIT, 8, instruction id width (write-back tag, unused for storage)
- FBK_DEPTH, 2, feedback buffer entries (>=1)
- REG_ID_BIT, $clog2(NUM_REG), register index width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- read_req_vld  in  1  read request valid
- read_req_rdy  out  1  read request accepted when high with vld
- read_reg0_id  in  REG_ID_BIT  source register 0
- read_reg1_id  in  REG_ID_BIT  source register 1
- read_fbk_vld  out  1  operand values valid
- read_fbk_rdy  in  1  unit accepts operand values
- read_reg0_val  out  REG_BIT  value of source 0
- read_reg1_val  out  REG_BIT  value of source 1
- write_back_vld  in  1  write-back valid
- write_back_rdy  out  1  write-back accepted
- write_back_id  in  INST_ID_BIT  instruction id (ignored)
- write_back_reg_id  in  REG_ID_BIT  destination register
- write_back_val  in  REG_BIT  value to write
- dbg_reg_id  in  REG_ID_BIT  debug peek index
- dbg_reg_val  out  REG_BIT  combinational peek of the register array (no bypass)
- idle  out  1  feedback buffer empty

Behaviour:
- Reset (rst_n low at posedge clk):
  - All registers cleared to 0.
  - Feedback buffer emptied.
  - read_fbk_vld=0, read_req_rdy=1, idle=1.
  - read_reg*_val are don't-care while vld=0.
- Reset asserted mid-operation discards buffered feedback. No request or write is accepted in that cycle.
- write_back_rdy is tied 1. A write is committed at the posedge where write_back_vld=1.
- read_req_rdy = (count < FBK_DEPTH). It is a registered state function with no combinational path from read_fbk_rdy or read_req_vld.
- On accept (vld && rdy):
  - Both source values are sampled that cycle.
  - The entry is pushed into the feedback buffer.
  - Latency is 1: read_fbk_vld rises the cycle after accept when the buffer was empty.
- Feedback buffer behaviour:
  - In-order FIFO.
  - read_fbk_vld = (count != 0).
  - Outputs are taken from the head entry and held stable while vld && !rdy.
  - Pop on read_fbk_vld && read_fbk_rdy.
- Simultaneous push and pop: count unchanged. Push is allowed only if count < FBK_DEPTH at the start of the cycle, so a full buffer does not accept a push even when it pops that cycle.
- Wrap-around: read/write pointers are modulo FBK_DEPTH. Count width is $clog2(FBK_DEPTH+1).
- Values already captured in the buffer are never altered by later writes.
- reg0_id == reg1_id is legal; both outputs carry the same value.
- idle = (count == 0).

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: when a write commits in the same cycle as a read accept and write_back_reg_id matches reg0_id and/or reg1_id, the matching sampled value is write_back_val (write-first).
- Undefined: the sample takes the pre-write array contents (read-first). The scoreboard must then delay the read one cycle after write-back.
- dbg_reg_val is unaffected in both cases.

Decomposition:
- Package rf_pkg: default width localparams (REG_BIT, REG_ID_BIT, INST_ID_BIT).
- Package rf_pkg: struct typedef for a feedback entry {reg0_val, reg1_val}.
- One sub-module, rf_fbk_fifo: synchronous FIFO with parameterised depth and width; vld/rdy out, count-based full.
- Register array, sampling and bypass muxes stay in the top module.

Test Plan:
- Reset, then write r3=0x1234 and r5=0x00FF in consecutive cycles; request (3,5) -> next cycle fbk_vld=1, val0=0x1234, val1=0x00FF; dbg_reg_id=3 shows 0x1234.
- With RF_WRITE_BYPASS_EN: write r2=0xBEEF and request (2,2) in the same cycle -> fbk val0=val1=0xBEEF. Without the macro -> 0x0000 from the reset value.
- Hold read_fbk_rdy=0 and issue three back-to-back requests with FBK_DEPTH=2 -> read_req_rdy drops after the 2nd accept; the 3rd stalls; fbk outputs stay stable on entry 1.
- Release read_fbk_rdy -> entries pop in order; the 3rd request is accepted the cycle after the first pop; idle=1 after the last pop.
- Capture (4,4) with r4=7, then write r4=9 while the entry is stalled -> popped values remain 7.
- Assert rst_n=0 for one cycle with 2 entries buffered and r1=0x55 -> next cycle fbk_vld=0, idle=1, dbg r1=0.
